// File: rtl/regfile_r2w1.sv
// rtl/regfile_r2w1.sv - 32x32 register file, two registered read ports, one write port, $0 hardwired to zero
module regfile_r2w1 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NREGS      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ren1,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic                  ren2,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] readdata1,
    output logic [DATA_WIDTH-1:0] readdata2,
    output logic                  rvalid1,
    output logic                  rvalid2
);

    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic [DATA_WIDTH-1:0] regs_d [NREGS];
    logic [DATA_WIDTH-1:0] readdata1_q, readdata1_d;
    logic [DATA_WIDTH-1:0] readdata2_q, readdata2_d;
    logic                  rvalid1_q, rvalid1_d;
    logic                  rvalid2_q, rvalid2_d;

    // Next storage contents: apply the write, then force $0 back to zero so
    // a write to index 0 is simply discarded.
    always_comb begin
        regs_d = regs_q;
        if (wen && (waddr != '0)) begin
            regs_d[waddr] = writedata;
        end
        regs_d[0] = '0;
    end

    // Read ports sample the post-write view, which gives write-through bypass
    // and the $0 rule for free; a disabled port holds its last data.
    always_comb begin
        readdata1_d = readdata1_q;
        readdata2_d = readdata2_q;
        rvalid1_d   = ren1;
        rvalid2_d   = ren2;
        if (ren1) begin
            readdata1_d = regs_d[raddr1];
        end
        if (ren2) begin
            readdata2_d = regs_d[raddr2];
        end
    end

    // Storage and output registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            readdata1_q <= '0;
            readdata2_q <= '0;
            rvalid1_q   <= 1'b0;
            rvalid2_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            readdata1_q <= readdata1_d;
            readdata2_q <= readdata2_d;
            rvalid1_q   <= rvalid1_d;
            rvalid2_q   <= rvalid2_d;
        end
    end

    assign readdata1 = readdata1_q;
    assign readdata2 = readdata2_q;
    assign rvalid1   = rvalid1_q;
    assign rvalid2   = rvalid2_q;

endmodule

// File: tb/tb_regfile_r2w1.sv
// tb/tb_regfile_r2w1.sv - randomized and directed bench for regfile_r2w1 against a behavioural model
module tb_regfile_r2w1;

    logic        clk;
    logic        reset;
    logic        ren1, ren2, wen;
    logic [4:0]  raddr1, raddr2, waddr;
    logic [31:0] writedata;
    logic [31:0] readdata1, readdata2;
    logic        rvalid1, rvalid2;

    regfile_r2w1 dut (
        .clk       (clk),
        .reset     (reset),
        .ren1      (ren1),
        .raddr1    (raddr1),
        .ren2      (ren2),
        .raddr2    (raddr2),
        .wen       (wen),
        .waddr     (waddr),
        .writedata (writedata),
        .readdata1 (readdata1),
        .readdata2 (readdata2),
        .rvalid1   (rvalid1),
        .rvalid2   (rvalid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem [32];
    logic [31:0] e_rd1, e_rd2;
    logic        e_rv1, e_rv2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0)                 return 32'h0;
        else if (wen && (waddr == a))  return writedata;
        else                           return mem[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        e_rd1 = 32'h0; e_rd2 = 32'h0; e_rv1 = 1'b0; e_rv2 = 1'b0;
    endtask

    task automatic tick(input string tag);
        if (ren1) e_rd1 = model_read(raddr1);
        if (ren2) e_rd2 = model_read(raddr2);
        e_rv1 = ren1;
        e_rv2 = ren2;
        if (wen && (waddr != 5'd0)) mem[waddr] = writedata;
        @(posedge clk);
        #1;
        check({tag, ".rvalid1"},   {31'h0, rvalid1}, {31'h0, e_rv1});
        check({tag, ".rvalid2"},   {31'h0, rvalid2}, {31'h0, e_rv2});
        check({tag, ".readdata1"}, readdata1, e_rd1);
        check({tag, ".readdata2"}, readdata2, e_rd2);
    endtask

    task automatic idle_inputs();
        ren1 = 0; ren2 = 0; wen = 0;
        raddr1 = 0; raddr2 = 0; waddr = 0; writedata = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        model_clear();
        #3;
        check("rst.readdata1", readdata1, 32'h0);
        check("rst.readdata2", readdata2, 32'h0);
        check("rst.rvalid1", {31'h0, rvalid1}, 32'h0);
        check("rst.rvalid2", {31'h0, rvalid2}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Reset clear
        wen = 1; waddr = 5; writedata = 32'hDEADBEEF;
        tick("rc.wr");
        idle_inputs();
        ren1 = 1; ren2 = 1; raddr1 = 5; raddr2 = 5;
        reset = 1'b0;
        model_clear();
        #1;
        check("rc.in_rst.rvalid1", {31'h0, rvalid1}, 32'h0);
        check("rc.in_rst.rvalid2", {31'h0, rvalid2}, 32'h0);
        @(posedge clk); #1;
        check("rc.edge_rst.rvalid1", {31'h0, rvalid1}, 32'h0);
        check("rc.edge_rst.rvalid2", {31'h0, rvalid2}, 32'h0);
        reset = 1'b1;
        ren2 = 0;
        tick("rc.rd");
        check("rc.r5_zero", readdata1, 32'h0);
        check("rc.r5_valid", {31'h0, rvalid1}, 32'h1);

        // Basic write/read
        idle_inputs();
        wen = 1; waddr = 7;  writedata = 32'h1234ABCD; tick("bw.w7");
        wen = 1; waddr = 31; writedata = 32'hDFDF7878; tick("bw.w31");
        idle_inputs();
        ren1 = 1; raddr1 = 7; ren2 = 1; raddr2 = 31;
        tick("bw.rd");
        check("bw.r7", readdata1, 32'h1234ABCD);
        check("bw.r31", readdata2, 32'hDFDF7878);

        // $0 hardwired
        idle_inputs();
        wen = 1; waddr = 0; writedata = 32'hFFFFFFFF; ren1 = 1; raddr1 = 0;
        tick("z.same");
        check("z.same_zero", readdata1, 32'h0);
        wen = 0;
        tick("z.next");
        check("z.next_zero", readdata1, 32'h0);

        // Bypass
        idle_inputs();
        wen = 1; waddr = 9; writedata = 32'h00000011; tick("by.init");
        wen = 1; waddr = 9; writedata = 32'h00000022; ren1 = 1; raddr1 = 9; ren2 = 1; raddr2 = 9;
        tick("by.same");
        check("by.new1", readdata1, 32'h00000022);
        check("by.new2", readdata2, 32'h00000022);
        wen = 0; ren2 = 0;
        tick("by.after");
        check("by.after_val", readdata1, 32'h00000022);

        // Hold and valid
        idle_inputs();
        ren1 = 1; raddr1 = 7; tick("hv.rd");
        check("hv.r7", readdata1, 32'h1234ABCD);
        ren1 = 0; wen = 1; waddr = 7; writedata = 32'h55555555;
        for (int i = 0; i < 3; i++) begin
            tick("hv.hold");
            check("hv.hold_rvalid", {31'h0, rvalid1}, 32'h0);
            check("hv.hold_data", readdata1, 32'h1234ABCD);
        end
        wen = 0; ren1 = 1; raddr1 = 7;
        tick("hv.reread");
        check("hv.new_r7", readdata1, 32'h55555555);

        // Randomized traffic with address range biased for collisions
        for (int i = 0; i < 400; i++) begin
            ren1 = 1'($urandom); ren2 = 1'($urandom); wen = 1'($urandom);
            raddr1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            raddr2 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            waddr  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            writedata = $urandom;
            tick("rnd");
        end

        // Asynchronous reset mid-read
        idle_inputs();
        wen = 1; waddr = 7; writedata = 32'hA5A5A5A5; tick("ar.wr");
        wen = 0; ren1 = 1; raddr1 = 7; tick("ar.rd");
        check("ar.pre", readdata1, 32'hA5A5A5A5);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check("ar.async_data", readdata1, 32'h0);
        check("ar.async_valid", {31'h0, rvalid1}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ren1 = 1; raddr1 = 5'(2 * i); ren2 = 1; raddr2 = 5'(2 * i + 1);
            tick("ar.scan");
            check("ar.scan_zero1", readdata1, 32'h0);
            check("ar.scan_zero2", readdata2, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
